// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - round-robin voice allocator sharing tone generators between piano keys
//
// Purpose: a scanner visits one key per clock. A newly pressed key takes the
// lowest-index free voice, or steals the oldest voice when every voice is busy.
// The clamped octave is latched per voice at allocation time.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   key           debounced key levels, 1 = pressed
//   scale         current octave from the scale selector (clamped on latch)
//   sustain       pedal, 1 = hold (present only when VOICE_SUSTAIN_EN is defined)
//   voice_active  per-voice sounding flag
//   voice_key     per-voice key index, voice v at [v*KEY_W +: KEY_W]
//   voice_scale   per-voice latched octave, voice v at [v*8 +: 8]
//   alloc_pulse   1-clk strobe on every (re)assignment
//   alloc_voice   voice index of the most recent assignment
//   steal_pulse   1-clk strobe when the assignment replaced a sounding voice
//
// Optional feature macro: VOICE_SUSTAIN_EN (adds the sustain pedal input).

module voice_allocator #(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4,
    parameter int MIN_SCALE  = 1,
    parameter int FULL_SCALE = 5,
    localparam int KEY_W     = $clog2(NUM_KEYS),
    localparam int VOICE_W   = $clog2(NUM_VOICES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_KEYS-1:0]           key,
    input  logic [7:0]                    scale,
`ifdef VOICE_SUSTAIN_EN
    input  logic                          sustain,
`endif
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
    output logic [NUM_VOICES*8-1:0]       voice_scale,
    output logic                          alloc_pulse,
    output logic [VOICE_W-1:0]            alloc_voice,
    output logic                          steal_pulse
);

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [KEY_W-1:0]                     scan_ptr_q, scan_ptr_d;
    logic [NUM_KEYS-1:0]                  served_q, served_d;
    logic [NUM_VOICES-1:0]                active_q, active_d;
    logic [NUM_VOICES-1:0][KEY_W-1:0]     vkey_q, vkey_d;
    logic [NUM_VOICES-1:0][7:0]           vscale_q, vscale_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]     age_q, age_d;
    logic                                 alloc_pulse_q, alloc_pulse_d;
    logic [VOICE_W-1:0]                   alloc_voice_q, alloc_voice_d;
    logic                                 steal_pulse_q, steal_pulse_d;

    logic                                 release_en;
    logic [7:0]                           scale_clamped;
    logic                                 free_found;
    logic [VOICE_W-1:0]                   free_idx;
    logic [VOICE_W-1:0]                   oldest_idx;
    logic [AGE_W-1:0]                     oldest_age;
    logic [VOICE_W-1:0]                   target;
    logic                                 key_now;

`ifdef VOICE_SUSTAIN_EN
    assign release_en = ~sustain;
`else
    assign release_en = 1'b1;
`endif

    assign key_now = key[scan_ptr_q];

    always_comb begin
        scale_clamped = scale;
        if (scale < 8'(MIN_SCALE)) begin
            scale_clamped = 8'(MIN_SCALE);
        end else if (scale > 8'(FULL_SCALE)) begin
            scale_clamped = 8'(FULL_SCALE);
        end
    end

    // Lowest-index inactive voice: scanning downwards lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                free_found = 1'b1;
                free_idx   = VOICE_W'(v);
            end
        end
    end

    // Oldest voice: strict greater-than keeps the lowest index on ties.
    always_comb begin
        oldest_idx = '0;
        oldest_age = age_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > oldest_age) begin
                oldest_age = age_q[v];
                oldest_idx = VOICE_W'(v);
            end
        end
    end

    assign target = free_found ? free_idx : oldest_idx;

    always_comb begin
        scan_ptr_d    = (scan_ptr_q == KEY_W'(NUM_KEYS - 1)) ? '0 : scan_ptr_q + 1'b1;
        served_d      = served_q;
        active_d      = active_q;
        vkey_d        = vkey_q;
        vscale_d      = vscale_q;
        age_d         = age_q;
        alloc_pulse_d = 1'b0;
        alloc_voice_d = alloc_voice_q;
        steal_pulse_d = 1'b0;

        if (key_now && !served_q[scan_ptr_q]) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && (age_q[v] != AGE_MAX)) begin
                    age_d[v] = age_q[v] + 1'b1;
                end
            end
            active_d[target]     = 1'b1;
            vkey_d[target]       = scan_ptr_q;
            vscale_d[target]     = scale_clamped;
            age_d[target]        = '0;
            served_d[scan_ptr_q] = 1'b1;
            alloc_pulse_d        = 1'b1;
            alloc_voice_d        = target;
            steal_pulse_d        = ~free_found;
        end else if (!key_now) begin
            served_d[scan_ptr_q] = 1'b0;
            if (release_en) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (active_q[v] && (vkey_q[v] == scan_ptr_q)) begin
                        active_d[v] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_ptr_q    <= '0;
            served_q      <= '0;
            active_q      <= '0;
            vkey_q        <= '0;
            vscale_q      <= {NUM_VOICES{8'(MIN_SCALE)}};
            age_q         <= '0;
            alloc_pulse_q <= 1'b0;
            alloc_voice_q <= '0;
            steal_pulse_q <= 1'b0;
        end else begin
            scan_ptr_q    <= scan_ptr_d;
            served_q      <= served_d;
            active_q      <= active_d;
            vkey_q        <= vkey_d;
            vscale_q      <= vscale_d;
            age_q         <= age_d;
            alloc_pulse_q <= alloc_pulse_d;
            alloc_voice_q <= alloc_voice_d;
            steal_pulse_q <= steal_pulse_d;
        end
    end

    assign voice_active = active_q;
    assign voice_key    = vkey_q;
    assign voice_scale  = vscale_q;
    assign alloc_pulse  = alloc_pulse_q;
    assign alloc_voice  = alloc_voice_q;
    assign steal_pulse  = steal_pulse_q;

endmodule
